alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 39 +++
 rtl/alu_nbit.sv | 51 +++++
 rtl/alu_sequencer.sv | 137 +++++++++++++
 tb/tb_alu_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// ============================================================================
// Module      : alu_sequencer_pkg
// Description : Shared opcodes, FSM state type and default width for the
//               ALU sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package alu_sequencer_pkg;

    localparam int N_DEFAULT = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    function automatic logic op_writes(input logic [2:0] op);
        return (op != OP_NOP);
    endfunction

    function automatic logic op_is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_nbit.sv
// ============================================================================
// Module      : alu_nbit
// Description : Combinational N-bit ALU; carry is carry-out for ADD and
//               borrow for SUB.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_nbit
    import alu_sequencer_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] imm,
    output logic [N-1:0] result,
    output logic         carry
);

    logic [N:0] w_sum;

    always_comb begin
        w_sum  = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                w_sum  = {1'b0, a} + {1'b0, b};
                result = w_sum[N-1:0];
                carry  = w_sum[N];
            end
            OP_SUB: begin
                // Top bit of the widened difference is set exactly when a < b.
                w_sum  = {1'b0, a} - {1'b0, b};
                result = w_sum[N-1:0];
                carry  = w_sum[N];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_LDI:  result = imm;
            OP_MOV:  result = a;
            default: result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module      : alu_sequencer
// Description : Four-state (IDLE/READ/EXEC/WB) sequencer driving an external
//               two-entry register file through one ALU operation at a time.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [2:0]   op_code,
    input  logic         op_sa,
    input  logic         op_sb,
    input  logic         op_da,
    input  logic [N-1:0] op_imm,
    output logic         SA,
    output logic         SB,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] D,
    output logic         DA,
    output logic         W,
    output logic         done,
    output logic         carry,
    output logic         zero
);

    state_t       r_state;
    state_t       w_next;
    logic [2:0]   r_code;
    logic         r_sa;
    logic         r_sb;
    logic         r_da;
    logic [N-1:0] r_imm;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic [N-1:0] r_res;
    logic         r_carry;
    logic         r_zero;
    logic [N-1:0] w_res;
    logic         w_carry;
    logic         w_accept;

    assign w_accept = op_valid && (r_state == S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_READ;
            S_READ:  w_next = S_EXEC;
            S_EXEC:  w_next = S_WB;
            S_WB:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Captured fields only change on accept, so SA/SB naturally hold their
    // last value through WB and IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_code <= OP_ADD;
            r_sa   <= 1'b0;
            r_sb   <= 1'b0;
            r_da   <= 1'b0;
            r_imm  <= '0;
        end else if (w_accept) begin
            r_code <= op_code;
            r_sa   <= op_sa;
            r_sb   <= op_sb;
            r_da   <= op_da;
            r_imm  <= op_imm;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            if (r_state == S_READ) begin
                r_a <= A;
                r_b <= B;
            end
            if (r_state == S_EXEC && op_writes(r_code)) begin
                r_res  <= w_res;
                r_zero <= (w_res == '0);
                if (op_is_arith(r_code)) begin
                    r_carry <= w_carry;
                end
            end
        end
    end

    alu_nbit #(
        .N(N)
    ) u_alu (
        .op     (r_code),
        .a      (r_a),
        .b      (r_b),
        .imm    (r_imm),
        .result (w_res),
        .carry  (w_carry)
    );

    // W and done decode straight from state so an asynchronous reset drops
    // them immediately.
    assign op_ready = (r_state == S_IDLE);
    assign SA       = r_sa;
    assign SB       = r_sb;
    assign DA       = r_da;
    assign D        = r_res;
    assign W        = (r_state == S_WB) && op_writes(r_code);
    assign done     = (r_state == S_WB);
    assign carry    = r_carry;
    assign zero     = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Directed self-checking bench with a two-entry register file.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] op_code;
    logic       op_sa;
    logic       op_sb;
    logic       op_da;
    logic [3:0] op_imm;
    logic       SA;
    logic       SB;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] D;
    logic       DA;
    logic       W;
    logic       done;
    logic       carry;
    logic       zero;

    logic [3:0] rf [0:1];
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_wr  = 0;
    int         wr_base;

    alu_sequencer #(.N(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .op_sa    (op_sa),
        .op_sb    (op_sb),
        .op_da    (op_da),
        .op_imm   (op_imm),
        .SA       (SA),
        .SB       (SB),
        .A        (A),
        .B        (B),
        .D        (D),
        .DA       (DA),
        .W        (W),
        .done     (done),
        .carry    (carry),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    assign A = rf[SA];
    assign B = rf[SB];

    always @(posedge clk) begin
        if (W === 1'b1) begin
            rf[DA] <= D;
            n_wr   <= n_wr + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [2:0] code, input logic sa, input logic sb,
                          input logic da, input logic [3:0] imm);
        op_code = code;
        op_sa   = sa;
        op_sb   = sb;
        op_da   = da;
        op_imm  = imm;
    endtask

    // Call with clk low; returns just after the negedge following WB.
    task automatic run_op(input string tag, input logic [2:0] code, input logic sa,
                          input logic sb, input logic da, input logic [3:0] imm,
                          input logic exp_w, input logic [3:0] exp_d,
                          input logic exp_c, input logic exp_z);
        set_op(code, sa, sb, da, imm);
        op_valid = 1'b1;
        check_val({tag, ".ready_idle"}, op_ready, 1);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        @(negedge clk);
        check_val({tag, ".ready_read"}, op_ready, 0);
        check_val({tag, ".sa_read"}, SA, sa);
        @(negedge clk);
        check_val({tag, ".done_exec"}, done, 0);
        @(negedge clk);
        check_val({tag, ".done_wb"}, done, 1);
        check_val({tag, ".w_wb"}, W, exp_w);
        if (exp_w) begin
            check_val({tag, ".d"}, D, exp_d);
            check_val({tag, ".da"}, DA, da);
        end
        check_val({tag, ".carry"}, carry, exp_c);
        check_val({tag, ".zero"}, zero, exp_z);
        @(negedge clk);
        check_val({tag, ".done_after"}, done, 0);
        check_val({tag, ".w_after"}, W, 0);
        check_val({tag, ".ready_after"}, op_ready, 1);
        if (exp_w) begin
            check_val({tag, ".rf"}, rf[da], exp_d);
        end
    endtask

    initial begin
        rst      = 1'b0;
        op_valid = 1'b0;
        set_op(OP_NOP, 1'b0, 1'b0, 1'b0, 4'h0);
        #1;
        check_val("rst.ready", op_ready, 1);
        check_val("rst.w", W, 0);
        check_val("rst.done", done, 0);
        check_val("rst.addr", {SA, SB, DA}, 0);
        check_val("rst.d", D, 0);
        check_val("rst.flags", {carry, zero}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // First op accepted on the first rising edge after release.
        run_op("ldi_a",  OP_LDI, 0, 0, 1, 4'hA, 1, 4'hA, 0, 0);
        run_op("ldi_9",  OP_LDI, 0, 0, 0, 4'h9, 1, 4'h9, 0, 0);
        run_op("ldi_8",  OP_LDI, 0, 0, 1, 4'h8, 1, 4'h8, 0, 0);
        run_op("add",    OP_ADD, 0, 1, 0, 4'h0, 1, 4'h1, 1, 0);
        run_op("mov",    OP_MOV, 0, 0, 1, 4'h0, 1, 4'h1, 1, 0);
        run_op("nop",    OP_NOP, 0, 1, 0, 4'h0, 0, 4'h0, 1, 0);
        run_op("ldi_3",  OP_LDI, 0, 0, 1, 4'h3, 1, 4'h3, 1, 0);
        run_op("sub_eq", OP_SUB, 1, 1, 0, 4'h0, 1, 4'h0, 0, 1);
        run_op("ldi_2",  OP_LDI, 0, 0, 0, 4'h2, 1, 4'h2, 0, 0);
        run_op("ldi_5",  OP_LDI, 0, 0, 1, 4'h5, 1, 4'h5, 0, 0);
        run_op("sub_bw", OP_SUB, 0, 1, 0, 4'h0, 1, 4'hD, 1, 0);
        run_op("and",    OP_AND, 0, 1, 1, 4'h0, 1, 4'h5, 1, 0);
        run_op("or",     OP_OR,  0, 1, 1, 4'h0, 1, 4'hD, 1, 0);
        run_op("xor",    OP_XOR, 0, 1, 0, 4'h0, 1, 4'h0, 1, 1);

        // Back-to-back ops with op_valid held high; the ADD reads the value
        // written by the preceding LDI without stalling.
        wr_base  = n_wr;
        set_op(OP_LDI, 0, 0, 0, 4'h7);
        op_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            check_val("pipe.ready", op_ready, (i % 4 == 0) ? 1 : 0);
            @(posedge clk);
            #1;
            if (i == 0) set_op(OP_LDI, 0, 0, 1, 4'h6);
            if (i == 4) set_op(OP_ADD, 0, 1, 0, 4'h0);
            if (i == 8) op_valid = 1'b0;
            @(negedge clk);
        end
        check_val("pipe.writes", n_wr - wr_base, 3);
        check_val("pipe.r0", rf[0], 4'hD);
        check_val("pipe.r1", rf[1], 4'h6);
        check_val("pipe.flags", {carry, zero}, 2'b00);

        run_op("ldi_f",  OP_LDI, 0, 0, 0, 4'hF, 1, 4'hF, 0, 0);
        run_op("add_ff", OP_ADD, 0, 0, 1, 4'h0, 1, 4'hE, 1, 0);

        // Abort in EXEC: state and flags clear at once, nothing gets written.
        set_op(OP_ADD, 0, 0, 1, 4'h0);
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_val("abort_exec.w", W, 0);
        check_val("abort_exec.ready", op_ready, 1);
        check_val("abort_exec.flags", {carry, zero}, 2'b00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("abort_exec.r1", rf[1], 4'hE);

        // Abort in WB: W falls asynchronously and the pending write is lost.
        set_op(OP_LDI, 0, 0, 0, 4'h0);
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_val("abort_wb.w_before", W, 1);
        check_val("abort_wb.zero_before", zero, 1);
        #2;
        rst = 1'b0;
        #1;
        check_val("abort_wb.w", W, 0);
        check_val("abort_wb.done", done, 0);
        check_val("abort_wb.zero", zero, 0);
        @(negedge clk);
        rst = 1'b1;
        check_val("abort_wb.r0", rf[0], 4'hF);
        run_op("post_rst", OP_LDI, 0, 0, 0, 4'h3, 1, 4'h3, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
